// File: rtl/instr_issue_seq.sv
// Decode/issue sequencer for the 16-bit register file: takes one instruction at a time and
// steps the register-file controls, ALU start and data-memory request through their phases.
module instr_issue_seq #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        mem_ack,
  output logic [1:0]  func,
  output logic        en_rg,
  output logic [23:0] addr,
  output logic [7:0]  imm_in,
  output logic [3:0]  alu_op,
  output logic        alu_go,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_EXEC, S_WB, S_MEM, S_LWB, S_HALT
  } state_t;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;

  logic [1:0]  cls;
  logic [23:0] addr_fmt;
  logic [7:0]  imm_fmt;
  logic        instr_unused;

  assign cls          = instr_q[31:30];
  assign alu_op       = instr_q[29:26];
  assign instr_unused = instr_q[24];

  always_comb begin
    addr_fmt = {16'h0000, instr_q[7:0]};
    imm_fmt  = '0;
    if (cls == 2'b00) begin
      addr_fmt = instr_q[23:0];
    end else if (cls == 2'b01) begin
      addr_fmt = {8'h00, instr_q[15:0]};
      imm_fmt  = instr_q[23:16];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  // Outputs are decoded from state so an async reset drives the idle encoding immediately.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    instr_ready = 1'b0;
    func        = 2'b11;
    en_rg       = 1'b1;
    addr        = '0;
    imm_in      = '0;
    alu_go      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    retire      = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          unique case (instr[31:30])
            2'b11:   state_d = S_HALT;
            2'b10:   state_d = instr[25] ? S_ISSUE : S_MEM;
            default: state_d = S_ISSUE;
          endcase
        end
      end
      S_ISSUE: begin
        func    = cls;
        addr    = addr_fmt;
        imm_in  = imm_fmt;
        cnt_d   = '0;
        state_d = (cls == 2'b10) ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        addr   = addr_fmt;
        imm_in = imm_fmt;
        alu_go = (cnt_q == '0);
        if (cnt_q == EXEC_LAST) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WB: begin
        func    = cls;
        en_rg   = 1'b0;
        addr    = addr_fmt;
        imm_in  = imm_fmt;
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      S_MEM: begin
        addr     = addr_fmt;
        mem_req  = 1'b1;
        mem_we   = instr_q[25];
        mem_addr = instr_q[23:8];
        if (mem_ack) begin
          if (instr_q[25]) begin
            retire  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LWB;
          end
        end
      end
      S_LWB: begin
        func    = 2'b10;
        en_rg   = 1'b0;
        addr    = {16'h0000, instr_q[7:0]};
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/instr_issue_seq.md
Name: instr_issue_seq

Overview:
- Decode/issue sequencer directly upstream of the 16-bit register file.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and drives the register file's func/en_rg/addr/imm_in controls in the correct phase order (operand read, execute wait, write-back).
- Sequences the data-memory request for load/store and pulses the ALU start.
- Exactly one instruction in flight; no pipelining.

Parameters:
EXEC_CYCLES, 1, cycles between alu_go and wb_data valid (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
instr  input  32  instruction word; sampled when instr_valid && instr_ready
instr_valid  input  1  upstream has an instruction
instr_ready  output  1  block can accept an instruction (high only in IDLE)
mem_ack  input  1  memory completed request; load data valid on load_in and held until next mem_req
func  output  2  register-file operation select
en_rg  output  1  1 = register-file read phase, 0 = write phase
addr  output  24  register-file address bundle {src1, src2, dst}
imm_in  output  8  immediate to register file
alu_op  output  4  ALU operation, held from issue until retire
alu_go  output  1  one-cycle ALU start pulse
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = store, 0 = load; valid while mem_req
mem_addr  output  16  memory address, instr[23:8]
retire  output  1  one-cycle pulse when an instruction completes
halted  output  1  high after a HALT instruction until reset

Behaviour:
- Instruction format: [31:30] class (00 R, 01 I, 10 MEM, 11 HALT); [29:26] alu_op; [25] MEM direction (1 store, 0 load); [24] ignored.
- Address and immediate per class:
  - R: addr = instr[23:0].
  - I: imm_in = instr[23:16], addr = {8'h00, instr[15:0]}.
  - MEM: addr = {16'h0000, instr[7:0]}.
- Safe idle encoding is func=2'b11, en_rg=1. The register file writes whenever en_rg=0 with func 00/01/10, so en_rg=0 appears only in write-back cycles.
- Reset (async, any state, including mid-operation):
  - State to IDLE; counter cleared; captured instruction register cleared.
  - Outputs: func=11, en_rg=1, addr=0, imm_in=0, alu_op=0, alu_go=0, mem_req=0, mem_we=0, mem_addr=0, retire=0, halted=0, instr_ready=1.
  - Any outstanding mem_ack after reset is ignored.
- States:
  - IDLE: instr_ready=1, idle encoding. On handshake, capture instr. Next state by class: ISSUE for R/I/store, MEM for load, HALT for class 11.
  - ISSUE (1 cycle): func=class, en_rg=1, addr/imm per format. Next state EXEC for R/I, MEM for store (register file captures store_in at end of this cycle).
  - EXEC: alu_go=1 in the first EXEC cycle only; func=11, en_rg=1; count EXEC_CYCLES cycles, then WB.
  - WB (exactly 1 cycle): func=class, en_rg=0, addr held (dst=addr[7:0]); retire=1; next IDLE.
  - MEM: func=11, en_rg=1; mem_req=1, mem_we=instr[25], mem_addr=instr[23:8]. Wait for mem_ack; mem_req drops the cycle after ack is sampled. On ack, store goes to IDLE with retire=1; load goes to LWB.
  - LWB (1 cycle): func=10, en_rg=0, addr={16'h0, instr[7:0]}; retire=1; next IDLE.
  - HALT: halted=1, instr_ready=0, idle encoding; exit only by rst.
- mem_ack outside MEM is ignored.
- instr_valid while not ready: instr is not sampled; upstream holds it.
- Back-to-back instructions: the earliest next acceptance is the cycle after WB/LWB/store-ack, giving a minimum R/I occupancy of 3+EXEC_CYCLES cycles including IDLE.
- alu_op is held from capture until the next capture.

Test Plan:
- Reset mid-EXEC with rst pulsed asynchronously between edges → outputs return to idle values immediately; counter and captured instruction cleared; instr_ready=1.
- R instr 0x04_01_02_03 (alu_op=1), EXEC_CYCLES=2 → sequence is:
  - ISSUE: func=00, en_rg=1, addr=0x010203.
  - EXEC: alu_go for one cycle, then 2 cycles total.
  - WB: func=00, en_rg=0 for one cycle with retire=1.
  - No en_rg=0 in any other cycle.
- I instr {01,0000,00,0x7F,0x02,0x05} → ISSUE drives imm_in=0x7F, addr=0x000205; WB writes dst 0x05.
- Store {10,0000,1,0,0x1234,0x09} with mem_ack after 3 wait cycles → ISSUE func=10/en_rg=1/addr=0x000009, then mem_req=1, mem_we=1, mem_addr=0x1234 for 4 cycles; retire on ack; func never 10 with en_rg=0.
- Load {10,0000,0,0,0x00AA,0x07}, ack after 1 cycle → mem_req with mem_we=0, then LWB func=10, en_rg=0, addr=0x000007; instr_valid held high throughout is not re-sampled until IDLE.
- HALT (class 11) → halted=1 and instr_ready=0 persist for 10+ cycles despite instr_valid; cleared only by rst.
